s27_sig_compactor: RTL and testbench

Downstream response compactor for the s27 sequential core. Samples the core's single output G17 over a programmed number of qualified cycles. Folds the samples into a serial CRC-style MISR signature and, optionally, a count of ones. Presents the result over a valid/ready readout handshake, so a test controller can compare the core's response against a golden signature.

---
 rtl/s27_sig_compactor.sv | 95 +++++++++
 tb/tb_s27_sig_compactor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s27_sig_compactor.sv
// Response compactor for the s27 core: folds qualified G17 samples into a serial MISR signature.
// Define S27_SIGCMP_ONES_CNT_EN to build the ones counter; otherwise ones_cnt is tied to 0.
module s27_sig_compactor #(
    parameter int               SIG_W = 16,
    parameter int               CNT_W = 8,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             G17,
    input  logic             sample_en,
    output logic             busy,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             take;
    logic             last;
    logic             fb;
    logic [SIG_W-1:0] sig_nxt;

    // Readout handshake: rd_valid is high for the whole of DONE and the result is
    // held until the edge where rd_valid && rd_ready, which completes the transfer.
    assign accept = (state == ST_IDLE) && start;
    assign take   = (state == ST_RUN) && sample_en;
    assign last   = take && (remaining == CNT_W'(1));

    assign fb      = sig[SIG_W-1] ^ G17;
    assign sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    assign busy      = (state == ST_RUN);
    assign rd_valid  = (state == ST_DONE);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last) state_nxt = ST_DONE;
            ST_DONE: if (rd_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state     <= ST_IDLE;
            remaining <= '0;
            sig       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sig       <= SEED;
                remaining <= len;
            end else if (take) begin
                sig       <= sig_nxt;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef S27_SIGCMP_ONES_CNT_EN
    logic [CNT_W-1:0] ones_q;

    // Counts at most len samples per run, so it never passes len.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            ones_q <= '0;
        end else if (accept) begin
            ones_q <= '0;
        end else if (take && G17) begin
            ones_q <= ones_q + CNT_W'(1);
        end
    end

    assign ones_cnt = ones_q;
`else
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_s27_sig_compactor.sv
// Self-checking bench for s27_sig_compactor: directed cases plus randomized runs against a behavioural model.
module tb_s27_sig_compactor;

    localparam int               SIG_W = 16;
    localparam int               CNT_W = 8;
    localparam logic [SIG_W-1:0] POLY  = 16'h1021;
    localparam logic [SIG_W-1:0] SEED  = 16'hFFFF;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len_in;
    logic             g17;
    logic             sample_en;
    logic             busy;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] ones_cnt;
    logic             rd_valid;
    logic             rd_ready;
    logic [1:0]       state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [SIG_W-1:0] exp_q[$];
    bit               en_pat[$];
    bit               g_pat[$];
    bit               smp_q[$];
    logic [SIG_W-1:0] held_sig;
    logic [CNT_W-1:0] held_ones;
    logic [SIG_W-1:0] ref_sig;

    s27_sig_compactor #(
        .SIG_W(SIG_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start),
        .len            (len_in),
        .G17            (g17),
        .sample_en      (sample_en),
        .busy           (busy),
        .sig            (sig),
        .ones_cnt       (ones_cnt),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    // reference model: signature as a shift/xor over the collected sample list
    function automatic logic [SIG_W-1:0] model_sig();
        int s;
        int msb;
        s = int'(SEED);
        foreach (smp_q[i]) begin
            msb = (s >> (SIG_W - 1)) & 1;
            s   = (s * 2) % (1 << SIG_W);
            if ((msb ^ int'(smp_q[i])) != 0) s = s ^ int'(POLY);
        end
        return s[SIG_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] model_ones();
        int c;
        c = 0;
`ifdef S27_SIGCMP_ONES_CNT_EN
        foreach (smp_q[i]) c += int'(smp_q[i]);
`endif
        return c[CNT_W-1:0];
    endfunction

    // driver: start a run of n samples from IDLE and follow it into DONE
    task automatic run_and_check(input string tag, input int n, input int gap_pct);
        int got;
        int cyc;
        bit e;
        bit g;
        smp_q.delete();
        start     = 1'b1;
        len_in    = n[CNT_W-1:0];
        sample_en = 1'($urandom_range(1));
        g17       = 1'($urandom_range(1));
        step();
        start = 1'b0;
        if (n == 0) begin
            chk({tag, "_zl_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_zl_busy"}, 32'(busy), 32'd0);
        end else begin
            got = 0;
            cyc = 0;
            while (got < n && cyc < 4000) begin
                chk({tag, "_run_busy"}, 32'(busy), 32'd1);
                chk({tag, "_run_valid"}, 32'(rd_valid), 32'd0);
                e = (en_pat.size() != 0) ? en_pat.pop_front() : ($urandom_range(99) >= gap_pct);
                g = (g_pat.size() != 0) ? g_pat.pop_front() : 1'($urandom_range(1));
                sample_en = e;
                g17       = g;
                start     = 1'($urandom_range(1));
                len_in    = CNT_W'($urandom);
                rd_ready  = 1'($urandom_range(1));
                step();
                cyc++;
                if (e) begin
                    smp_q.push_back(g);
                    got++;
                end
            end
            chk({tag, "_samples_taken"}, 32'(got), 32'(n));
            sample_en = 1'b0;
            start     = 1'b0;
            rd_ready  = 1'b0;
            chk({tag, "_done_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        end
        exp_q.push_back(model_sig());
        held_sig  = exp_q.pop_front();
        held_ones = model_ones();
        chk({tag, "_sig"}, 32'(sig), 32'(held_sig));
        chk({tag, "_ones"}, 32'(ones_cnt), 32'(held_ones));
    endtask

    // driver: hold the result in DONE for hold cycles (start pulsed), then read it out
    task automatic finish_read(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            rd_ready = 1'b0;
            start    = (i % 3 == 0);
            len_in   = CNT_W'($urandom_range(1, 255));
            step();
            chk({tag, "_hold_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
            chk({tag, "_hold_sig"}, 32'(sig), 32'(held_sig));
            chk({tag, "_hold_ones"}, 32'(ones_cnt), 32'(held_ones));
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk({tag, "_rd_valid_low"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_rd_sig_held"}, 32'(sig), 32'(held_sig));
        chk({tag, "_rd_ones_held"}, 32'(ones_cnt), 32'(held_ones));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len_in    = '0;
        g17       = 1'b0;
        sample_en = 1'b0;
        rd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // idle with rd_ready high and no start: nothing happens
        rd_ready = 1'b1;
        repeat (3) step();
        rd_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_sig", 32'(sig), 32'd0);

        // single zero sample
        en_pat = '{1'b1};
        g_pat  = '{1'b0};
        run_and_check("one_zero", 1, 0);
        chk("one_zero_const", 32'(sig), 32'h0000EFDF);
        finish_read("one_zero", 0);

        // single one sample
        en_pat = '{1'b1};
        g_pat  = '{1'b1};
        run_and_check("one_one", 1, 0);
        chk("one_one_const", 32'(sig), 32'h0000FFFE);
        finish_read("one_one", 1);

        // zero length
        run_and_check("zero_len", 0, 0);
        chk("zero_len_const", 32'(sig), 32'h0000FFFF);
        finish_read("zero_len", 0);

        // ungapped 1,0,1 reference then gapped version of the same samples
        en_pat = '{1'b1, 1'b1, 1'b1};
        g_pat  = '{1'b1, 1'b0, 1'b1};
        run_and_check("ungapped", 3, 0);
        ref_sig = sig;
        finish_read("ungapped", 0);
        en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        g_pat  = '{1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1};
        run_and_check("gapped", 3, 0);
        chk("gapped_eq_ungapped", 32'(sig), 32'(ref_sig));
`ifdef S27_SIGCMP_ONES_CNT_EN
        chk("gapped_ones_const", 32'(ones_cnt), 32'd2);
`endif

        // backpressure with start pulses, then a start right after the readout
        finish_read("backpressure", 10);
        run_and_check("after_bp", 5, 30);
        finish_read("after_bp", 2);

        // maximum length, all ones
        for (int i = 0; i < 255; i++) g_pat.push_back(1'b1);
        run_and_check("max_len", 255, 0);
        finish_read("max_len", 1);

        // randomized runs
        for (int r = 0; r < 14; r++) begin
            run_and_check("rand", $urandom_range(1, 24), $urandom_range(0, 60));
            finish_read("rand", $urandom_range(0, 4));
        end

        // reset mid-RUN
        start  = 1'b1;
        len_in = 8'd10;
        step();
        start     = 1'b0;
        sample_en = 1'b1;
        g17       = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_sig", 32'(sig), 32'd0);
        chk("midrun_rst_ones", 32'(ones_cnt), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_valid", 32'(rd_valid), 32'd0);
        sample_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_sig", 32'(sig), 32'd0);

        // reset mid-DONE
        run_and_check("pre_done_rst", 4, 20);
        rst_n = 1'b0;
        #1;
        chk("middone_rst_valid", 32'(rd_valid), 32'd0);
        chk("middone_rst_sig", 32'(sig), 32'd0);
        chk("middone_rst_ones", 32'(ones_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_and_check("recover", 6, 25);
        finish_read("recover", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
